// File: rtl/car_sensor_gen.sv
// Purpose: emulates the two light-barrier sensors (a = outer, b = inner) for one car passage.
// Latency: start taken at edge N -> a/b non-zero from cycle N+1 -> done pulse in cycle N+1+3*DWELL.
// Backpressure: none; start is only sampled in IDLE, and a start seen while busy is dropped.
//
// Ports:
//   clk   - single clock, all state updates on its rising edge
//   reset - synchronous active-high reset
//   start - request one passage (sampled only in IDLE)
//   dir   - direction sampled with start: 0 = enter, 1 = exit
//   a, b  - registered sensor outputs, 1 = beam blocked
//   busy  - high while a passage is in progress
//   done  - single-cycle pulse in the first IDLE cycle after a passage
//   occ   - occupancy estimate (0..7)
//
// Build option: define CAR_SENSOR_GEN_OCC_EN to enable the saturating occupancy
// tracker. Without it, occ is tied to 0 and no occupancy register exists.

module car_sensor_gen #(
  parameter int DWELL = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dir,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic [2:0] occ
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PH1  = 2'b01,
    PH2  = 2'b10,
    PH3  = 2'b11
  } state_t;

  // The counter is loaded with DWELL-1 on phase entry, so a phase lasts exactly DWELL cycles.
  localparam logic [7:0] LP_RELOAD = 8'(DWELL - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_dir;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;

  logic       w_last;

  assign w_last = (r_cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_dir   <= 1'b0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= PH1;
            r_dir   <= dir;
            r_cnt   <= LP_RELOAD;
            r_busy  <= 1'b1;
            // Enter blocks the outer beam first; exit blocks the inner beam first.
            r_a     <= ~dir;
            r_b     <= dir;
          end
        end
        PH1: begin
          if (w_last) begin
            r_state <= PH2;
            r_cnt   <= LP_RELOAD;
            r_a     <= 1'b1;
            r_b     <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        PH2: begin
          if (w_last) begin
            r_state <= PH3;
            r_cnt   <= LP_RELOAD;
            // The beam that was blocked first clears first.
            r_a     <= r_dir;
            r_b     <= ~r_dir;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        PH3: begin
          if (w_last) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign a    = r_a;
  assign b    = r_b;
  assign busy = r_busy;
  assign done = r_done;

`ifdef CAR_SENSOR_GEN_OCC_EN
  logic [2:0] r_occ;
  logic       w_finish;

  // Updated on the same edge that raises done, so occ is current in the done cycle.
  assign w_finish = (r_state == PH3) && w_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ <= 3'd0;
    end else if (w_finish) begin
      if (!r_dir) begin
        if (r_occ != 3'd7) r_occ <= r_occ + 3'd1;
      end else begin
        if (r_occ != 3'd0) r_occ <= r_occ - 3'd1;
      end
    end
  end

  assign occ = r_occ;
`else
  assign occ = 3'd0;
`endif

endmodule
